// File: rtl/dcf77_pkg.sv
// Shared defaults and channel state encodings for the pulse stretcher array.
package dcf77_pkg;

    localparam int CNT_W_DEF   = 28;
    localparam int DEF_LEN_DEF = 5000000;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } ch_state_e;

endpackage

// File: rtl/monostable_channel.sv
// One monostable channel: trigger synchroniser, rising-edge detect, length
// register, period down-counter and IDLE/ACTIVE state machine.
module monostable_channel
    import dcf77_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int DEF_LEN = DEF_LEN_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_trig,
    input  logic             i_retrig_en,
    input  logic             i_len_we,
    input  logic [CNT_W-1:0] i_len_data,
    output logic             o_pulse,
    output logic             o_done
);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_sync3;
    logic             r_edge;
    logic [1:0]       r_vld;
    logic             r_armed;
    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] r_cnt;
    ch_state_e        r_state;
    logic             r_pulse;
    logic             r_done;

    logic             w_edge_det;
    logic [CNT_W-1:0] w_load_len;

    // Edges are only accepted once a genuine low has been seen after reset,
    // so a trigger held high through reset cannot fire a pulse.
    assign w_edge_det = r_sync2 & ~r_sync3 & r_armed;
    assign w_load_len = (r_len == '0) ? CNT_W'(1) : r_len;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
            r_edge  <= 1'b0;
            r_vld   <= 2'b00;
            r_armed <= 1'b0;
        end else begin
            r_sync1 <= i_trig;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            r_edge  <= w_edge_det;
            r_vld   <= {r_vld[0], 1'b1};
            if (r_vld[1] && !r_sync2) begin
                r_armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_len <= CNT_W'(DEF_LEN);
        end else if (i_len_we) begin
            r_len <= i_len_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_pulse <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_edge) begin
                        r_state <= ST_ACTIVE;
                        r_cnt   <= w_load_len;
                        r_pulse <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    // A retrigger beats the terminal count, so the final
                    // cycle can still be extended without a low gap.
                    if (r_edge && i_retrig_en) begin
                        r_cnt <= w_load_len;
                    end else if (r_cnt <= CNT_W'(1)) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_pulse <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_pulse <= 1'b0;
                end
            endcase
        end
    end

    assign o_pulse = r_pulse;
    assign o_done  = r_done;

endmodule

// File: rtl/pulse_stretcher_array.sv
// Array of independent monostable pulse stretchers with a shared length-write
// port addressed by channel index.
module pulse_stretcher_array
    import dcf77_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int DEF_LEN = DEF_LEN_DEF
) (
    input  logic             clk_in,
    input  logic             gsr_n,
    input  logic [N_CH-1:0]  trig_in,
    input  logic [N_CH-1:0]  retrig_en,
    input  logic             len_we,
    input  logic [3:0]       len_sel,
    input  logic [CNT_W-1:0] len_data,
    output logic [N_CH-1:0]  pulse_out,
    output logic [N_CH-1:0]  done_out
);

    logic [N_CH-1:0] w_we;

    // Indices at or above N_CH match no channel and are dropped.
    always_comb begin
        w_we = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_we[i] = len_we && (len_sel == 4'(i));
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        monostable_channel #(
            .CNT_W   (CNT_W),
            .DEF_LEN (DEF_LEN)
        ) u_ch (
            .i_clk       (clk_in),
            .i_rst_n     (gsr_n),
            .i_trig      (trig_in[g]),
            .i_retrig_en (retrig_en[g]),
            .i_len_we    (w_we[g]),
            .i_len_data  (len_data),
            .o_pulse     (pulse_out[g]),
            .o_done      (done_out[g])
        );
    end

endmodule
